bram_sdp_pipe: RTL and testbench

- Parametrised simple-dual-port block RAM (one write port, one read port) for the probability-circuit datapath: node parameter and intermediate result storage.
- Adds features the current storage does not have:
  - byte-lane write enables
  - configurable read pipeline latency
  - selectable read-during-write semantics
  - out-of-range address detection
  - post-reset memory-clear sequencer
- Sits between the input loader and the PE array; one read and one write per cycle.

---
 rtl/bram_sdp_pipe.sv | 171 +++++++++++++++++
 tb/tb_bram_sdp_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_sdp_pipe
// Purpose  : Simple-dual-port block RAM with byte-lane writes, pipelined reads
//            and a post-reset clear sequencer.
// Revision : 1.0
// ============================================================================
module bram_sdp_pipe #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 256,
  parameter int DEPTH          = 256,
  parameter int BYTE_W         = 8,
  parameter int RD_LATENCY     = 1,
  parameter int WR_MODE        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_data_vld,
  output logic                         rd_oor,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/BYTE_W-1:0] wr_be,
  output logic                         init_busy
);

  localparam int NB = DATA_WIDTH / BYTE_W;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  init_busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == LAST_ADDR) begin
        state_q     <= ST_RUN;
        init_busy_q <= 1'b0;
      end
    end
  end

  assign init_busy = init_busy_q;

  logic run, rd_inr, wr_inr, rd_acc, wr_acc, coll;
  assign run    = (state_q == ST_RUN);
  assign rd_inr = ({1'b0, rd_addr} < DEPTH_X);
  assign wr_inr = ({1'b0, wr_addr} < DEPTH_X);
  assign rd_acc = run & re;
  assign wr_acc = run & we & wr_inr;
  assign coll   = rd_acc & rd_inr & wr_acc & (rd_addr == wr_addr);

  // The clear sequencer borrows the single write port while user traffic is blocked.
  logic [NB-1:0]         mem_be;
  logic [IW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    mem_be    = '0;
    mem_waddr = wr_addr[IW-1:0];
    mem_wdata = wr_data;
    if (state_q == ST_CLEAR) begin
      mem_be    = '1;
      mem_waddr = clr_cnt_q[IW-1:0];
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_be    = wr_be;
    end
  end

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (mem_be[i]) begin
        mem[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
      end
    end
    ram_q <= mem[rd_addr[IW-1:0]];
  end

  logic                  vld0_q, oor0_q, coll_q;
  logic [DATA_WIDTH-1:0] cwdata_q;
  logic [NB-1:0]         cbe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q <= 1'b0;
      oor0_q <= 1'b0;
      coll_q <= 1'b0;
    end else begin
      vld0_q <= rd_acc;
      oor0_q <= rd_acc & ~rd_inr;
      coll_q <= coll;
    end
    cwdata_q <= wr_data;
    cbe_q    <= wr_be;
  end

  // Write-first bypass: overlay the enabled lanes of the colliding write on the old word.
  logic [DATA_WIDTH-1:0] s0_data;

  always_comb begin
    s0_data = ram_q;
    if ((WR_MODE != 0) && coll_q) begin
      for (int i = 0; i < NB; i++) begin
        if (cbe_q[i]) begin
          s0_data[i*BYTE_W +: BYTE_W] = cwdata_q[i*BYTE_W +: BYTE_W];
        end
      end
    end
    if (!vld0_q || oor0_q) begin
      s0_data = '0;
    end
  end

  generate
    if (RD_LATENCY <= 1) begin : g_lat1
      assign rd_data     = s0_data;
      assign rd_data_vld = vld0_q;
      assign rd_oor      = oor0_q;
    end else begin : g_latn
      localparam int NS = RD_LATENCY - 1;
      logic [DATA_WIDTH-1:0] data_q [NS];
      logic [NS-1:0]         vld_q;
      logic [NS-1:0]         oor_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_q <= '0;
          oor_q <= '0;
          for (int i = 0; i < NS; i++) begin
            data_q[i] <= '0;
          end
        end else begin
          data_q[0] <= s0_data;
          vld_q[0]  <= vld0_q;
          oor_q[0]  <= oor0_q;
          for (int i = 1; i < NS; i++) begin
            data_q[i] <= data_q[i-1];
            vld_q[i]  <= vld_q[i-1];
            oor_q[i]  <= oor_q[i-1];
          end
        end
      end

      assign rd_data     = data_q[NS-1];
      assign rd_data_vld = vld_q[NS-1];
      assign rd_oor      = oor_q[NS-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_bram_sdp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sdp_pipe
// Purpose  : Scoreboard bench for bram_sdp_pipe across three configurations.
// Revision : 1.0
// ============================================================================
module tb_bram_sdp_pipe;

  localparam int DW = 256;
  localparam int AW = 8;
  localparam int NB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst [3];
  logic          re [3];
  logic          we [3];
  logic          vld [3];
  logic          oor [3];
  logic          busy [3];
  logic [AW-1:0] rd_addr [3];
  logic [AW-1:0] wr_addr [3];
  logic [DW-1:0] wr_data [3];
  logic [DW-1:0] rd_data [3];
  logic [NB-1:0] wr_be [3];

  // inst 0: defaults; inst 1: latency 3, write-first, depth 200; inst 2: latency 4
  bram_sdp_pipe u0 (
    .clk(clk), .rst(rst[0]), .re(re[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
    .rd_data_vld(vld[0]), .rd_oor(oor[0]), .we(we[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wr_be(wr_be[0]), .init_busy(busy[0])
  );

  bram_sdp_pipe #(.DEPTH(200), .RD_LATENCY(3), .WR_MODE(1)) u1 (
    .clk(clk), .rst(rst[1]), .re(re[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
    .rd_data_vld(vld[1]), .rd_oor(oor[1]), .we(we[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_be(wr_be[1]), .init_busy(busy[1])
  );

  bram_sdp_pipe #(.RD_LATENCY(4)) u2 (
    .clk(clk), .rst(rst[2]), .re(re[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
    .rd_data_vld(vld[2]), .rd_oor(oor[2]), .we(we[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .wr_be(wr_be[2]), .init_busy(busy[2])
  );

  typedef struct packed {
    int            inst;
    int            due;
    logic [DW-1:0] data;
    logic          oor;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  function automatic int lat(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      for (int k = 0; k < 3; k++) begin
        if (vld[k] === 1'b1) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_vld inst=%0d cycle=%0d got vld=1 required vld=0", k, cyc);
          end else begin
            e = sb.pop_front();
            if (e.inst != k || e.due != cyc) begin
              errors++;
              $display("FAIL read_timing got inst=%0d cycle=%0d required inst=%0d cycle=%0d",
                       k, cyc, e.inst, e.due);
            end
            checks++;
            if (rd_data[k] !== e.data) begin
              errors++;
              $display("FAIL read_data inst=%0d cycle=%0d got %h required %h", k, cyc, rd_data[k], e.data);
            end
            checks++;
            if (oor[k] !== e.oor) begin
              errors++;
              $display("FAIL read_oor inst=%0d cycle=%0d got %b required %b", k, cyc, oor[k], e.oor);
            end
          end
        end else begin
          checks++;
          if (vld[k] !== 1'b0 || rd_data[k] !== '0 || oor[k] !== 1'b0) begin
            errors++;
            $display("FAIL idle_outputs inst=%0d cycle=%0d got vld=%b oor=%b data=%h required zeros",
                     k, cyc, vld[k], oor[k], rd_data[k]);
          end
        end
      end
      if (sb.size() > 0 && sb[0].due < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_read inst=%0d got no vld by cycle %0d required at cycle %0d",
                 sb[0].inst, cyc, sb[0].due);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int k, input int a, input logic [DW-1:0] d, input logic [NB-1:0] be);
    we[k] = 1'b1; wr_addr[k] = AW'(a); wr_data[k] = d; wr_be[k] = be;
    tick();
    we[k] = 1'b0;
  endtask

  task automatic push(input int k, input logic [DW-1:0] d, input logic o);
    exp_t e;
    e.inst = k; e.due = cyc + lat(k); e.data = d; e.oor = o;
    sb.push_back(e);
  endtask

  task automatic rd(input int k, input int a, input logic [DW-1:0] d, input logic o);
    re[k] = 1'b1; rd_addr[k] = AW'(a);
    push(k, d, o);
    tick();
    re[k] = 1'b0;
  endtask

  task automatic rdwr(input int k, input int a, input logic [DW-1:0] wd, input logic [DW-1:0] d);
    we[k] = 1'b1; wr_addr[k] = AW'(a); wr_data[k] = wd; wr_be[k] = '1;
    re[k] = 1'b1; rd_addr[k] = AW'(a);
    push(k, d, 1'b0);
    tick();
    re[k] = 1'b0; we[k] = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending reads required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic count_busy(input int k, output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy[k] !== 1'b1) break;
      n++;
    end
  endtask

  initial begin
    int n;
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; re[k] = 1'b0; we[k] = 1'b0;
      rd_addr[k] = '0; wr_addr[k] = '0; wr_data[k] = '0; wr_be[k] = '0;
    end
    tick();
    tick();
    mon_en = 1'b1;
    checks++;
    if (busy[0] !== 1'b1 || vld[0] !== 1'b0 || rd_data[0] !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b vld=%b required busy=1 vld=0", busy[0], vld[0]);
    end
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;

    count_busy(0, n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_busy_cycles got %0d required 256", n);
    end
    checks++;
    if (busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL other_clear_done got busy1=%b busy2=%b required 0 0", busy[1], busy[2]);
    end
    rd(0, 0, '0, 1'b0);
    rd(0, 128, '0, 1'b0);
    rd(0, 255, '0, 1'b0);
    drain();

    wr(0, 5, '1, '1);
    wr(0, 5, '0, 32'h0000_0001);
    rd(0, 5, {{31{8'hFF}}, 8'h00}, 1'b0);
    wr(0, 5, '0, '0);
    rd(0, 5, {{31{8'hFF}}, 8'h00}, 1'b0);
    drain();

    wr(0, 7, {32{8'hAA}}, '1);
    rdwr(0, 7, {32{8'h55}}, {32{8'hAA}});
    rd(0, 7, {32{8'h55}}, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) wr(1, i, DW'(i), '1);
    for (int i = 0; i < 10; i++) rd(1, i, DW'(i), 1'b0);
    drain();

    wr(1, 7, {32{8'hAA}}, '1);
    rdwr(1, 7, {32{8'h55}}, {32{8'h55}});
    rd(1, 7, {32{8'h55}}, 1'b0);
    drain();

    wr(1, 199, {8{32'hCAFE_0199}}, '1);
    wr(1, 250, '1, '1);
    rd(1, 250, '0, 1'b1);
    rd(1, 199, {8{32'hCAFE_0199}}, 1'b0);
    drain();

    wr(2, 3, {8{32'h1234_5678}}, '1);
    rd(2, 3, {8{32'h1234_5678}}, 1'b0);
    drain();
    rd(2, 3, {8{32'h1234_5678}}, 1'b0);
    rd(2, 3, {8{32'h1234_5678}}, 1'b0);
    rd(2, 3, {8{32'h1234_5678}}, 1'b0);
    rst[2] = 1'b1;
    sb.delete();
    tick();
    rst[2] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (vld[2] !== 1'b0) begin
        errors++;
        $display("FAIL vld_after_rst cycle=%0d got %b required 0", cyc, vld[2]);
      end
    end
    checks++;
    if (busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_rst got %b required 1", busy[2]);
    end

    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    count_busy(0, n);
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_restart_cycles got %0d required 256", n);
    end
    rd(0, 5, '0, 1'b0);
    rd(0, 7, '0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
